// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared types for the AES core scheduler.
// FSM states, keylen encodings, tag-pipeline entry.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWITCH,
    FLUSH
  } state_e;

  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

  // Widest requester ID (NUM_REQ up to 8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/aes_core_sched_if.sv
// aes_core_sched_if: requester-side valid/ready bundle.
// master = requesters (valid/data/key/keylen out), slave = scheduler.
interface aes_core_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 128
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_keylen;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*KEY_WIDTH-1:0]  req_key;

  modport master (
    output req_valid,
    output req_data,
    output req_key,
    output req_keylen,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_key,
    input  req_keylen,
    output req_ready
  );

endinterface

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: round-robin priority picker, first request at/after i_ptr.
// Ports: i_req, i_ptr in; o_gnt (one-hot), o_idx, o_any out.
module aes_rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = 0; i < N; i++) begin
      w_k = W'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_idx      = w_k;
        o_gnt[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_sched.sv
// aes_core_sched: round-robin scheduler sharing one pipelined AES core.
// Ports: clk, rst (async low), req_if (slave), core_* drive/return,
// res_* result bus, flush_req/flush_done, busy.
// Optional AES_SCHED_STATS_EN adds stat_issued / stat_stall counters.
module aes_core_sched
  import aes_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CORE_LATENCY = 10,
  parameter  int KEY_WIDTH    = 128,
  parameter  int DATA_WIDTH   = 128,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_core_sched_if.slave       req_if,
  output logic                  core_valid_in,
  output logic [DATA_WIDTH-1:0] core_plaintext,
  output logic [KEY_WIDTH-1:0]  core_key,
  output logic                  core_keylen,
  input  logic [DATA_WIDTH-1:0] core_ciphertext,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [DATA_WIDTH-1:0] res_data,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CORE_LATENCY + 1);

  state_e             r_state;
  state_e             w_state_nx;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_nx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic               w_win_kl;
  logic               w_empty;
  logic               w_issue;
  logic               w_kl_load;
  logic [CNT_W-1:0]   r_inflight;
  logic [ID_W-1:0]    r_issue_id;
  tag_t               r_tag [CORE_LATENCY];

  aes_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .i_req (req_if.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_win_kl = req_if.req_keylen[w_idx];
  assign w_empty  = (r_inflight == '0);
  assign w_ptr_nx = (w_idx == ID_W'(NUM_REQ - 1))
                  ? '0 : w_idx + 1'b1;

  // A keylen change is only safe with nothing in the core,
  // so a mismatching winner parks the FSM in SWITCH.
  always_comb begin
    w_state_nx = r_state;
    w_issue    = 1'b0;
    w_kl_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_issue    = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (w_any && (w_empty || w_win_kl == core_keylen))
          w_issue = 1'b1;
        else if (w_any)
          w_state_nx = SWITCH;
        else if (w_empty)
          w_state_nx = IDLE;
      end
      SWITCH: begin
        if (w_empty) begin
          w_kl_load  = w_any;
          w_state_nx = RUN;
        end
      end
      FLUSH: begin
        if (!flush_req)
          w_state_nx = w_empty ? IDLE : RUN;
      end
      default: w_state_nx = IDLE;
    endcase
    if (flush_req) begin
      w_state_nx = FLUSH;
      w_issue    = 1'b0;
      w_kl_load  = 1'b0;
    end
    // Grant is combinational; keep it quiet while held in reset.
    if (!rst) begin
      w_issue   = 1'b0;
      w_kl_load = 1'b0;
    end
  end

  assign req_if.req_ready = w_issue ? w_gnt : '0;
  assign flush_done = (r_state == FLUSH) && flush_req && w_empty;
  assign busy       = !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      core_valid_in  <= 1'b0;
      core_plaintext <= '0;
      core_key       <= '0;
      core_keylen    <= KEYLEN_128;
      r_issue_id     <= '0;
    end else begin
      r_state       <= w_state_nx;
      core_valid_in <= w_issue;
      if (w_issue) begin
        r_ptr          <= w_ptr_nx;
        r_issue_id     <= w_idx;
        core_keylen    <= w_win_kl;
        core_plaintext <=
          req_if.req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
        core_key       <=
          req_if.req_key[w_idx*KEY_WIDTH +: KEY_WIDTH];
      end else if (w_kl_load) begin
        core_keylen <= w_win_kl;
      end
    end
  end

  // Tag pipeline mirrors the core latency; stage 0 follows
  // the issue register so tags line up with core_valid_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CORE_LATENCY; i++)
        r_tag[i] <= '0;
    end else begin
      r_tag[0] <= tag_t'{valid: core_valid_in,
                         id:    ID_MAX_W'(r_issue_id)};
      for (int i = 1; i < CORE_LATENCY; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  assign res_valid = r_tag[CORE_LATENCY-1].valid;
  assign res_id    = r_tag[CORE_LATENCY-1].id[ID_W-1:0];
  assign res_data  = core_ciphertext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, res_valid})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  a_inflight_ovf: assert property (
    @(posedge clk) disable iff (!rst)
    !(w_issue && !res_valid && r_inflight == CNT_MAX));

`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (w_issue && stat_issued != '1)
        stat_issued <= stat_issued + 1'b1;
      if (r_state == SWITCH && stat_stall != '1)
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_core_sched.sv
// tb_aes_core_sched: random + directed bench with a stand-in core
// and a queue-based reference model of grants and results.
module tb_aes_core_sched;

  localparam int N  = 4;
  localparam int L  = 10;
  localparam int DW = 128;
  localparam int KW = 128;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_core_sched_if #(
    .NUM_REQ (N), .DATA_WIDTH (DW), .KEY_WIDTH (KW)
  ) req_if ();

  logic          core_valid_in;
  logic [DW-1:0] core_plaintext;
  logic [KW-1:0] core_key;
  logic          core_keylen;
  logic [DW-1:0] core_ciphertext;
  logic          res_valid;
  logic [IW-1:0] res_id;
  logic [DW-1:0] res_data;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          busy;
`ifdef AES_SCHED_STATS_EN
  logic [31:0]   stat_issued;
  logic [31:0]   stat_stall;
`endif

  aes_core_sched #(
    .NUM_REQ (N), .CORE_LATENCY (L),
    .KEY_WIDTH (KW), .DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_if          (req_if),
    .core_valid_in   (core_valid_in),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_keylen     (core_keylen),
    .core_ciphertext (core_ciphertext),
    .res_valid       (res_valid),
    .res_id          (res_id),
    .res_data        (res_data),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .busy            (busy)
`ifdef AES_SCHED_STATS_EN
    ,
    .stat_issued     (stat_issued),
    .stat_stall      (stat_stall)
`endif
  );

  // requester drive
  logic [N-1:0]    rv;
  logic [N-1:0]    rkl;
  logic [DW-1:0]   rd [N];
  logic [KW-1:0]   rk [N];
  logic [N*DW-1:0] w_data;
  logic [N*KW-1:0] w_key;

  always_comb begin
    w_data = '0;
    w_key  = '0;
    for (int i = 0; i < N; i++) begin
      w_data[i*DW +: DW] = rd[i];
      w_key[i*KW +: KW]  = rk[i];
    end
  end

  assign req_if.req_valid  = rv;
  assign req_if.req_keylen = rkl;
  assign req_if.req_data   = w_data;
  assign req_if.req_key    = w_key;

  // stand-in core: fixed L-cycle pipeline of a keyed transform
  function automatic logic [DW-1:0] core_fn(
    input logic [DW-1:0] p, input logic [KW-1:0] k, input logic kl);
    return {p[63:0], p[127:64]} ^ k[127:0] ^ {DW{kl}};
  endfunction

  logic [DW-1:0] core_pipe [L];
  always_ff @(posedge clk) begin
    core_pipe[0] <= core_fn(core_plaintext, core_key, core_keylen);
    for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_ciphertext = core_pipe[L-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference model
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            mptr = 0;
  int            n_issued = 0;
  int            n_stall = 0;
  int            gnt_cyc [N];
  int            last_res_cyc = 0;
  int            fd_first_cyc = -1;
  logic          mkl = 1'b0;
  logic          mswitch = 1'b0;
  logic          mflush = 1'b0;
  logic          prev_hs = 1'b0;
  logic [DW-1:0] last_pt = '0;
  logic [KW-1:0] last_key = '0;
  logic [N-1:0]  m_gnt = '0;

  task automatic model_reset();
    q.delete();
    mptr = 0; mkl = 1'b0; mswitch = 1'b0; mflush = 1'b0;
    prev_hs = 1'b0; last_pt = '0; last_key = '0; m_gnt = '0;
    n_issued = 0; n_stall = 0;
  endtask

  task automatic mon_cycle();
    int           win;
    int           k;
    int           out;
    logic         hs;
    logic         fd_exp;
    logic [N-1:0] eg;
    out = q.size();
    win = -1;
    for (int i = 0; i < N; i++) begin
      k = (mptr + i) % N;
      if (win < 0 && rv[IW'(k)]) win = k;
    end
    if (mswitch) n_stall++;
    fd_exp = flush_req && mflush && out == 0;
    chk("core_valid_in", core_valid_in, prev_hs);
    chk("core_plaintext", core_plaintext, last_pt);
    chk("core_key", core_key, last_key);
    chk("core_keylen", core_keylen, mkl);
    chk("busy", busy, out != 0);
    chk("flush_done", flush_done, fd_exp);
    if (fd_exp && fd_first_cyc < 0) fd_first_cyc = cyc;
    if (out > 0 && q[0].due == cyc) begin
      chk("res_valid", res_valid, 1'b1);
      chk("res_id", res_id, q[0].id);
      chk("res_data", res_data, q[0].data);
      last_res_cyc = cyc;
      void'(q.pop_front());
    end else begin
      chk("res_valid", res_valid, 1'b0);
    end
    hs = 1'b0;
    eg = '0;
    if (flush_req) begin
      mflush = 1'b1;
      mswitch = 1'b0;
    end else if (mflush) begin
      mflush = 1'b0;
    end else if (mswitch) begin
      if (out == 0) begin
        if (win >= 0) mkl = rkl[IW'(win)];
        mswitch = 1'b0;
      end
    end else if (win >= 0) begin
      if (rkl[IW'(win)] == mkl || out == 0) begin
        hs = 1'b1;
        eg[IW'(win)] = 1'b1;
        mkl = rkl[IW'(win)];
      end else begin
        mswitch = 1'b1;
      end
    end
    chk("req_ready", req_if.req_ready, eg);
    if (hs) begin
      q.push_back('{due: cyc + 1 + L, id: win,
        data: core_fn(rd[win], rk[win], rkl[IW'(win)])});
      last_pt  = rd[win];
      last_key = rk[win];
      mptr     = (win + 1) % N;
      gnt_cyc[win] = cyc;
      n_issued++;
    end
    prev_hs = hs;
    m_gnt   = eg;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (!rst) model_reset();
    else mon_cycle();
  end

  // stimulus
  int pv = 0;
  int pk = 0;

  task automatic set_req(input int i, input logic kl);
    rv[i]  = 1'b1;
    rkl[i] = kl;
    rd[i]  = {$urandom, $urandom, $urandom, $urandom};
    rk[i]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (m_gnt[i]) rv[i] = 1'b0;
      if (!rv[i] && $urandom_range(99) < pv)
        set_req(i, $urandom_range(99) < pk);
    end
  endtask

  task automatic step_until_out(input int n, input int budget);
    int c = 0;
    while (q.size() != n && c < budget) begin
      step();
      c++;
    end
    chk("wait_inflight", q.size(), n);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_if.req_ready, '0);
    chk({tag, "_core_valid_in"}, core_valid_in, 1'b0);
    chk({tag, "_core_plaintext"}, core_plaintext, '0);
    chk({tag, "_core_key"}, core_key, '0);
    chk({tag, "_core_keylen"}, core_keylen, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_id"}, res_id, '0);
    chk({tag, "_flush_done"}, flush_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rv  = '0;
    rkl = '0;
    for (int i = 0; i < N; i++) begin
      rd[i] = '0;
      rk[i] = '0;
      gnt_cyc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rv = '1;
    #1;
    check_reset_vals("por");
    rv  = '0;
    rst = 1'b1;

    // single block latency
    step();
    set_req(0, 1'b0);
    repeat (16) step();
    chk("single_lat", last_res_cyc - gnt_cyc[0], L + 1);

    // all requesters busy: rotation and back-to-back results
    pv = 100;
    pk = 0;
    repeat (40) step();
    pv = 0;
    repeat (20) step();

    // keylen switch forces a drain
    set_req(1, 1'b0);
    for (int c = 0; c < 10 && rv[1]; c++) step();
    set_req(2, 1'b1);
    repeat (20) step();
    chk("switch_gap", gnt_cyc[2] - gnt_cyc[1], L + 3);

    // flush with 5 blocks outstanding
    pv = 100;
    step_until_out(5, 30);
    flush_req    = 1'b1;
    fd_first_cyc = -1;
    repeat (20) step();
    chk("flush_gap", fd_first_cyc - last_res_cyc, 1);
    flush_req = 1'b0;
    pv = 0;
    rv = '0;
    repeat (5) step();

    // reset with 3 blocks outstanding
    pv = 100;
    step_until_out(3, 30);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("mid");
    pv = 0;
    rv = '0;
    repeat (2) step();
    rst = 1'b1;
    repeat (20) step();

    // random traffic with occasional flushes
    pv = 60;
    pk = 15;
    for (int b = 0; b < 12; b++) begin
      repeat ($urandom_range(60, 150)) step();
      flush_req = 1'b1;
      repeat ($urandom_range(2, 15)) step();
      flush_req = 1'b0;
    end
    pv = 0;
    repeat (60) step();
    chk("drained", q.size(), 0);

`ifdef AES_SCHED_STATS_EN
    chk("stat_issued", stat_issued, n_issued);
    chk("stat_stall", stat_stall, n_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_core_sched.md
# aes_core_sched

Round-robin scheduler sharing one fully pipelined AES encryption core among `NUM_REQ` requesters. Accepts at most one block per cycle and drives the core's `valid_in`/`plaintext_in`/`key_in`/`keyLen` from registers. Tracks each issued block's requester ID through a tag pipeline matched to the core latency, and returns ciphertext tagged with that ID. Because `keyLen` is global to the core, the scheduler drains in-flight blocks before any key-length change and provides an explicit flush.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CORE_LATENCY`, 10: cycles from core `valid_in` to ciphertext valid (10 for AES-128 build, 14 for AES-256 build).
- `KEY_WIDTH`, 128: core key width (128 or 256).
- `DATA_WIDTH`, 128: block width, fixed 128.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester block request.
- `req_ready` out NUM_REQ: one-hot grant, combinational; handshake = valid & ready.
- `req_data` in NUM_REQ*DATA_WIDTH: plaintext, requester i at slice i.
- `req_key` in NUM_REQ*KEY_WIDTH: key, requester i at slice i.
- `req_keylen` in NUM_REQ: 0 = 128-bit, 1 = 256-bit.
- `core_valid_in` out 1; `core_plaintext` out DATA_WIDTH; `core_key` out KEY_WIDTH; `core_keylen` out 1: registered core drive.
- `core_ciphertext` in DATA_WIDTH: core output.
- `res_valid` out 1; `res_id` out ID_W (clog2 NUM_REQ); `res_data` out DATA_WIDTH: result bus, no backpressure.
- `flush_req` in 1: level; stop granting and drain.
- `flush_done` out 1: high while flush requested and pipeline empty.
- `busy` out 1: in-flight count nonzero.

## Operation
- FSM states: IDLE, RUN, SWITCH, FLUSH.
- IDLE: in_flight = 0. A pending eligible request → RUN.
- RUN: the arbiter grants the first requester at or after `rr_ptr` with `req_valid`. On handshake at index g, `rr_ptr` ← (g+1) mod NUM_REQ.
- Key-length rule: if the winner's `req_keylen` ≠ `core_keylen` and in_flight ≠ 0, no grant is given and the FSM goes to SWITCH.
- SWITCH: `req_ready` = 0 until in_flight = 0. Then `core_keylen` ← winner's keylen and the FSM returns to RUN; the grant is given the following cycle.
- If in_flight = 0 the keylen updates in the same cycle as the grant, with no SWITCH.
- `flush_req` high in any state: FSM → FLUSH and `req_ready` = 0.
- FLUSH: `flush_done` = 1 once in_flight = 0. On `flush_req` low: → IDLE if in_flight = 0 (always true once done), else RUN.
- Tag pipeline: CORE_LATENCY stages of {valid, id}, shifting every cycle. Stage 0 is loaded from the issue register.
- Results: `res_valid`/`res_id` come from the last stage; `res_data` = `core_ciphertext` (combinational pass-through).
- in_flight counter, width clog2(CORE_LATENCY+2):
  - +1 on issue, −1 on retire (`res_valid`).
  - Simultaneous issue and retire: unchanged.
  - Never exceeds CORE_LATENCY+1. Overflow is an assertion error.
- `core_plaintext`/`core_key` hold their last value when `core_valid_in` = 0.

## Timing
- Handshake in cycle t → `core_valid_in` = 1 in t+1 → `res_valid` = 1 in t+1+CORE_LATENCY.
- Sustained throughput is one block per cycle when keylen is constant.
- A keylen switch costs in_flight drain cycles plus 1 cycle.
- Reset values: `req_ready` 0, `core_valid_in` 0, `core_plaintext` 0, `core_key` 0, `core_keylen` 0, `res_valid` 0, `res_id` 0, `flush_done` 0, `busy` 0, `rr_ptr` 0, FSM IDLE.
- `res_data` is undefined while `res_valid` = 0.
- Reset mid-operation clears all tags. In-flight blocks are discarded, and no `res_valid` is produced for them.

## Configuration
- `AES_SCHED_STATS_EN` defined:
  - Adds outputs `stat_issued` (32) and `stat_stall` (32). Both reset to 0 and saturate at all-ones.
  - `stat_issued` increments per handshake.
  - `stat_stall` increments per cycle in SWITCH.
- Not defined: these ports and counters are absent.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum (IDLE/RUN/SWITCH/FLUSH);
  - keylen encodings KEYLEN_128 = 0, KEYLEN_256 = 1;
  - the tag struct {valid, id}.
- Sub-module `aes_rr_arbiter` is the parameterised round-robin priority picker. Inputs: request vector and pointer. Outputs: one-hot grant and index.

## Test plan
- Single request: requester 0, key 000102…0f, plaintext 00112233…eeff, keylen 0 → `res_valid` at t+11, `res_id` 0, `res_data` 69c4e0d86a7b0430d8cdb78070b4c55a.
- All four requesters valid continuously → grants rotate 0,1,2,3,0…; 4 results in consecutive cycles in the same ID order.
- Requester 1 keylen 0 issued, then requester 2 keylen 1 requested next cycle → SWITCH for drain, `req_ready` = 0; grant to 2 only after requester 1's `res_valid`, with `core_keylen` = 1 at issue.
- `flush_req` raised with 5 blocks in flight → no grants; `flush_done` rises the cycle after the 5th `res_valid`.
- Reset asserted with 3 blocks in flight → all outputs immediately at reset values; no `res_valid` after release.
- With `AES_SCHED_STATS_EN`: 8 issues plus one 4-cycle SWITCH → `stat_issued` = 8, `stat_stall` = 4.
